// File: rtl/seg_reader.sv
// seg_reader
//   Watches a multiplexed 4-digit seven-segment display, waits for each digit
//   to be steady, decodes it, and publishes a full 4-digit frame once every
//   digit position has been captured.
//
// Parameters
//   STABLE_CYCLES  : identical qualified samples needed to capture a digit (2..255)
//   TIMEOUT_CYCLES : cycles without any capture before 'stale' rises (16..65535)
//
// Ports
//   clk          in   1   clock, rising edge
//   rst          in   1   synchronous active-high reset
//   seg          in   7   segment lines, active-high, bit0=a ... bit6=g
//   an           in   4   digit enables, active-low, an[k]=0 selects digit k
//   value        out 16   last published frame, nibble k = digit k
//   blank        out  4   per-digit "all segments off" flag of the last frame
//   frame_valid  out  1   one-cycle pulse when value/blank/frame_err update
//   frame_err    out  1   last frame held at least one unrecognised pattern
//   stale        out  1   no capture for TIMEOUT_CYCLES since the last frame
module seg_reader #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  output logic [15:0] value,
  output logic [3:0]  blank,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        stale
);

  localparam logic [1:0]  HUNT      = 2'd0;
  localparam logic [1:0]  COUNT     = 2'd1;
  localparam logic [1:0]  HELD      = 2'd2;
  localparam logic [7:0]  STABLE_N  = 8'(STABLE_CYCLES);
  localparam logic [15:0] TIMEOUT_N = 16'(TIMEOUT_CYCLES);

  // Pattern decoder: returns {err, blank, nibble}.
  function automatic logic [5:0] decode_seg(input logic [6:0] s);
    logic [5:0] r;
    case (s)
      7'h00:   r = 6'b01_0000;
      7'h3F:   r = {2'b00, 4'h0};
      7'h06:   r = {2'b00, 4'h1};
      7'h5B:   r = {2'b00, 4'h2};
      7'h4F:   r = {2'b00, 4'h3};
      7'h66:   r = {2'b00, 4'h4};
      7'h6D:   r = {2'b00, 4'h5};
      7'h7D:   r = {2'b00, 4'h6};
      7'h07:   r = {2'b00, 4'h7};
      7'h7F:   r = {2'b00, 4'h8};
      7'h6F:   r = {2'b00, 4'h9};
      7'h77:   r = {2'b00, 4'hA};
      7'h7C:   r = {2'b00, 4'hB};
      7'h39:   r = {2'b00, 4'hC};
      7'h5E:   r = {2'b00, 4'hD};
      7'h79:   r = {2'b00, 4'hE};
      7'h71:   r = {2'b00, 4'hF};
      default: r = 6'b10_0000;
    endcase
    return r;
  endfunction

  logic [6:0]  seg_r;
  logic [3:0]  an_r;
  logic [1:0]  state_r;
  logic [7:0]  cnt_r;
  logic [10:0] ref_r;
  logic [15:0] slot_value_r;
  logic [3:0]  slot_blank_r;
  logic [3:0]  slot_err_r;
  logic [3:0]  seen_r;
  logic [15:0] idle_r;

  logic        qual_s;
  logic [1:0]  digit_s;
  logic [10:0] sample_s;
  logic        match_s;
  logic [1:0]  state_s;
  logic [7:0]  cnt_s;
  logic [10:0] ref_s;
  logic        capture_s;
  logic        publish_s;
  logic        timeout_s;
  logic [5:0]  dec_s;
  logic [3:0]  seen_keep_s;
  logic [3:0]  capture_mask_s;

  assign sample_s  = {an_r, seg_r};
  assign match_s   = qual_s && (sample_s == ref_r);
  assign dec_s     = decode_seg(seg_r);
  assign publish_s = (seen_r == 4'hF);
  // Saturated idle counter never re-fires the timeout.
  assign timeout_s = !capture_s && (idle_r != TIMEOUT_N) && ((idle_r + 16'd1) == TIMEOUT_N);
  assign seen_keep_s    = (publish_s || timeout_s) ? 4'b0000 : seen_r;
  assign capture_mask_s = capture_s ? (4'b0001 << digit_s) : 4'b0000;

  // Input sampling register; every decision below uses this copy.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_r <= 7'd0;
      an_r  <= 4'hF;
    end else begin
      seg_r <= seg;
      an_r  <= an;
    end
  end

  // Qualification: exactly one active-low enable, and which digit it selects.
  always_comb begin
    qual_s  = 1'b0;
    digit_s = 2'd0;
    case (an_r)
      4'b1110: begin qual_s = 1'b1; digit_s = 2'd0; end
      4'b1101: begin qual_s = 1'b1; digit_s = 2'd1; end
      4'b1011: begin qual_s = 1'b1; digit_s = 2'd2; end
      4'b0111: begin qual_s = 1'b1; digit_s = 2'd3; end
      default: begin qual_s = 1'b0; digit_s = 2'd0; end
    endcase
  end

  // Stability FSM next-state: a differing qualified sample restarts the count at 1.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    ref_s     = ref_r;
    capture_s = 1'b0;
    case (state_r)
      HUNT: begin
        if (qual_s) begin
          state_s = COUNT;
          cnt_s   = 8'd1;
          ref_s   = sample_s;
        end else begin
          cnt_s   = 8'd0;
        end
      end
      COUNT: begin
        if (match_s) begin
          cnt_s = cnt_r + 8'd1;
          if ((cnt_r + 8'd1) == STABLE_N) begin
            capture_s = 1'b1;
            state_s   = HELD;
          end else begin
            state_s   = COUNT;
          end
        end else if (qual_s) begin
          state_s = COUNT;
          cnt_s   = 8'd1;
          ref_s   = sample_s;
        end else begin
          state_s = HUNT;
          cnt_s   = 8'd0;
        end
      end
      HELD: begin
        if (match_s) begin
          state_s = HELD;
        end else if (qual_s) begin
          state_s = COUNT;
          cnt_s   = 8'd1;
          ref_s   = sample_s;
        end else begin
          state_s = HUNT;
          cnt_s   = 8'd0;
        end
      end
      default: begin
        state_s = HUNT;
        cnt_s   = 8'd0;
      end
    endcase
  end

  // Stability FSM state, counter and reference pattern.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= HUNT;
      cnt_r   <= 8'd0;
      ref_r   <= 11'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      ref_r   <= ref_s;
    end
  end

  // Per-digit slot storage written on capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_value_r <= 16'd0;
      slot_blank_r <= 4'd0;
      slot_err_r   <= 4'd0;
    end else if (capture_s) begin
      slot_value_r[{digit_s, 2'b00} +: 4] <= dec_s[3:0];
      slot_blank_r[digit_s]               <= dec_s[4];
      slot_err_r[digit_s]                 <= dec_s[5];
    end else begin
      slot_value_r <= slot_value_r;
      slot_blank_r <= slot_blank_r;
      slot_err_r   <= slot_err_r;
    end
  end

  // Frame bookkeeping: seen mask, idle counter, stale flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      seen_r <= 4'd0;
      idle_r <= 16'd0;
      stale  <= 1'b0;
    end else begin
      seen_r <= seen_keep_s | capture_mask_s;
      if (capture_s) begin
        idle_r <= 16'd0;
      end else if (idle_r != TIMEOUT_N) begin
        idle_r <= idle_r + 16'd1;
      end else begin
        idle_r <= idle_r;
      end
      if (publish_s) begin
        stale <= 1'b0;
      end else if (timeout_s) begin
        stale <= 1'b1;
      end else begin
        stale <= stale;
      end
    end
  end

  // Published outputs, loaded the cycle after the seen mask fills.
  always_ff @(posedge clk) begin
    if (rst) begin
      value       <= 16'd0;
      blank       <= 4'd0;
      frame_err   <= 1'b0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= publish_s;
      if (publish_s) begin
        value     <= slot_value_r;
        blank     <= slot_blank_r;
        frame_err <= |slot_err_r;
      end else begin
        value     <= value;
        blank     <= blank;
        frame_err <= frame_err;
      end
    end
  end

endmodule

// File: tb/tb_seg_reader.sv
// Scoreboard bench for seg_reader: a run-length reference model predicts
// published frames; a negedge monitor compares whatever the DUT publishes.
module tb_seg_reader;
  localparam int S = 4;
  localparam int T = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  seg = 7'd0;
  logic [3:0]  an  = 4'hF;
  logic [15:0] value;
  logic [3:0]  blank;
  logic        frame_valid;
  logic        frame_err;
  logic        stale;

  seg_reader #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .seg(seg), .an(an),
    .value(value), .blank(blank), .frame_valid(frame_valid),
    .frame_err(frame_err), .stale(stale)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [15:0] v;
    logic [3:0]  b;
    logic        e;
  } frame_t;

  frame_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int fv_count = 0;
  int fv_cyc = -1000;

  logic [6:0] pat [0:15] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model state: run length of identical qualified samples and slots.
  int          m_run = 0;
  logic [10:0] m_prev = 11'd0;
  logic [3:0]  m_seen = 4'd0;
  logic [3:0]  m_nib [4];
  logic [3:0]  m_blank = 4'd0;
  logic [3:0]  m_err = 4'd0;
  int          m_idle = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_prev = 11'd0; m_seen = 4'd0; m_blank = 4'd0; m_err = 4'd0; m_idle = 0;
    for (int i = 0; i < 4; i++) m_nib[i] = 4'd0;
  endtask

  task automatic model_step(input logic [3:0] a, input logic [6:0] s);
    int k;
    bit found;
    frame_t f;
    if ($countones(~a) == 1) begin
      if (m_run > 0 && {a, s} == m_prev) m_run++;
      else m_run = 1;
      m_prev = {a, s};
    end else begin
      m_run = 0;
    end
    if (m_run == S) begin
      k = 0;
      for (int i = 0; i < 4; i++) if (a[i] == 1'b0) k = i;
      found = 0;
      m_nib[k] = 4'd0; m_blank[k] = 1'b0; m_err[k] = 1'b0;
      for (int i = 0; i < 16; i++) if (pat[i] == s) begin m_nib[k] = 4'(i); found = 1; end
      if (s == 7'd0) m_blank[k] = 1'b1;
      else if (!found) m_err[k] = 1'b1;
      m_seen[k] = 1'b1;
      m_idle = 0;
      if (m_seen == 4'hF) begin
        f.v = {m_nib[3], m_nib[2], m_nib[1], m_nib[0]};
        f.b = m_blank;
        f.e = |m_err;
        exp_q.push_back(f);
        m_seen = 4'd0;
      end
    end else if (m_idle < T) begin
      m_idle++;
      if (m_idle == T) m_seen = 4'd0;
    end
  endtask

  task automatic step(input logic [3:0] a, input logic [6:0] s);
    an = a; seg = s;
    model_step(a, s);
    @(posedge clk); #1;
  endtask

  task automatic dwell(input int k, input logic [6:0] s, input int len);
    logic [3:0] a;
    a = ~(4'b0001 << k);
    repeat (len) step(a, s);
  endtask

  task automatic gap(input logic [3:0] a, input int len);
    repeat (len) step(a, 7'd0);
  endtask

  task automatic do_reset();
    an = 4'hF; seg = 7'd0; rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // Monitor: pop and compare on every publish, and check outputs hold otherwise.
  frame_t last_pub = '0;
  initial begin
    frame_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        last_pub = '0;
      end else if (frame_valid) begin
        fv_count++;
        fv_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("frame_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("frame_value", 32'(value), 32'(e.v));
          check("frame_blank", 32'(blank), 32'(e.b));
          check("frame_err", 32'(frame_err), 32'(e.e));
          last_pub = e;
        end
      end else begin
        check("outputs_hold", 32'({value, blank, frame_err}), 32'({last_pub.v, last_pub.b, last_pub.e}));
      end
    end
  end

  initial begin
    int t_drive;
    int base;
    int k;
    int len;
    logic [6:0] s;
    logic [3:0] a;
    model_reset();
    do_reset();
    check("reset_value", 32'(value), 32'd0);
    check("reset_blank", 32'(blank), 32'd0);
    check("reset_err", 32'(frame_err), 32'd0);
    check("reset_fv", 32'(frame_valid), 32'd0);
    check("reset_stale", 32'(stale), 32'd0);

    // Basic scan 1,2,3,4 and latency from the final dwell's first sample.
    base = fv_count;
    dwell(0, 7'h06, 8);
    dwell(1, 7'h5B, 8);
    dwell(2, 7'h4F, 8);
    t_drive = cyc;
    dwell(3, 7'h66, 8);
    gap(4'hF, 3);
    check("scan_frame_count", 32'(fv_count - base), 32'd1);
    check("scan_value", 32'(value), 32'h4321);
    check("latency", 32'(fv_cyc - t_drive), 32'(S + 2));

    // Digit 2 dwell too short: no frame, then stale after the timeout.
    base = fv_count;
    repeat (3) begin
      dwell(0, 7'h3F, 8);
      dwell(1, 7'h06, 8);
      dwell(2, 7'h5B, 3);
      dwell(3, 7'h4F, 8);
    end
    check("short_dwell_no_frame", 32'(fv_count - base), 32'd0);
    check("stale_before_timeout", 32'(stale), 32'd0);
    gap(4'hF, T + 10);
    check("stale_after_timeout", 32'(stale), 32'd1);
    check("stale_value_held", 32'(value), 32'h4321);

    // Blank and unrecognised patterns.
    base = fv_count;
    dwell(0, 7'h7F, 8);
    dwell(1, 7'h6D, 8);
    dwell(2, 7'h07, 8);
    dwell(3, 7'h00, 8);
    gap(4'hF, 3);
    check("blank_frame_count", 32'(fv_count - base), 32'd1);
    check("blank_mask", 32'(blank), 32'b1000);
    check("stale_cleared", 32'(stale), 32'd0);
    dwell(0, 7'h3F, 8);
    dwell(1, 7'h01, 8);
    dwell(2, 7'h7C, 8);
    dwell(3, 7'h71, 8);
    gap(4'hF, 3);
    check("err_flag", 32'(frame_err), 32'd1);
    check("err_nibble", 32'(value[7:4]), 32'd0);

    // Unqualified enables between and inside dwells.
    base = fv_count;
    dwell(0, 7'h66, 2);
    gap(4'b1100, 20);
    dwell(0, 7'h66, 3);
    gap(4'hF, 20);
    dwell(1, 7'h77, 8);
    gap(4'b1100, 20);
    dwell(2, 7'h39, 8);
    gap(4'hF, 20);
    dwell(3, 7'h5E, 8);
    gap(4'hF, 5);
    check("split_dwell_no_frame", 32'(fv_count - base), 32'd0);
    dwell(0, 7'h79, 8);
    gap(4'hF, 3);
    check("gap_frame_count", 32'(fv_count - base), 32'd1);
    check("gap_value", 32'(value), 32'hDCAE);

    // Reset mid-frame discards partial captures.
    base = fv_count;
    dwell(0, 7'h06, 8);
    dwell(1, 7'h06, 8);
    dwell(2, 7'h06, 8);
    gap(4'hF, 4);
    do_reset();
    dwell(3, 7'h06, 8);
    gap(4'hF, 4);
    check("rst_no_frame", 32'(fv_count - base), 32'd0);
    check("rst_value", 32'(value), 32'd0);
    check("rst_flags", 32'({blank, frame_err, stale}), 32'd0);
    dwell(0, 7'h5B, 8);
    dwell(1, 7'h4F, 8);
    dwell(2, 7'h7D, 8);
    gap(4'hF, 3);
    check("rst_refill_frame", 32'(fv_count - base), 32'd1);
    check("rst_refill_value", 32'(value), 32'h1632);

    // Randomised scanning against the reference model.
    for (int n = 0; n < 350; n++) begin
      k = $urandom_range(0, 3);
      case ($urandom_range(0, 9))
        7: s = 7'd0;
        8, 9: s = 7'($urandom);
        default: s = pat[$urandom_range(0, 15)];
      endcase
      len = $urandom_range(1, 9);
      dwell(k, s, len);
      if ($urandom_range(0, 6) == 0) begin
        a = 4'($urandom);
        if ($countones(~a) == 1) a = 4'hF;
        gap(a, $urandom_range(1, 4));
      end
      if ($urandom_range(0, 99) == 0) begin
        gap(4'hF, 4);
        do_reset();
      end
    end
    gap(4'hF, 10);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
